// File: rtl/plab5_mcore_mem_req_net_adapter.sv
// Registers one memory request and emits a control flit, plus a data flit for writes.
// Optional outstanding-request credit limit: PLAB5_MCORE_MEM_NET_ADAPTER_CREDIT_EN.
module plab5_mcore_mem_req_net_adapter #(
    parameter int unsigned p_net_src           = 0,
    parameter int unsigned p_num_banks         = 2,
    parameter int unsigned p_dest_mode         = 1,
    parameter logic [31:0] p_inst_boundary     = 32'h4000,
    parameter logic [31:0] p_data_boundary     = 32'hc000,
    parameter int unsigned p_mem_opaque_nbits  = 8,
    parameter int unsigned p_mem_addr_nbits    = 32,
    parameter int unsigned p_mem_data_nbits    = 32,
    parameter int unsigned p_net_opaque_nbits  = 4,
    parameter int unsigned p_net_srcdest_nbits = 3,
    parameter int unsigned p_cacheline_nwords  = 4,
    parameter int unsigned p_max_outstanding   = 4,
    localparam int unsigned LenW = $clog2(p_mem_data_nbits / 8),
    localparam int unsigned CtlW = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + LenW,
    localparam int unsigned ReqW = CtlW + p_mem_data_nbits,
    localparam int unsigned NetW = 2 * p_net_srcdest_nbits + p_net_opaque_nbits + CtlW + 1,
    localparam int unsigned CntW = $clog2(p_max_outstanding + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mode,
    input  logic                        req_val,
    output logic                        req_rdy,
    input  logic [ReqW-1:0]             req_msg,
    output logic                        net_ctrl_val,
    input  logic                        net_ctrl_rdy,
    output logic [NetW-1:0]             net_ctrl_msg,
    output logic                        net_data_val,
    input  logic                        net_data_rdy,
    output logic [p_mem_data_nbits-1:0] net_data_msg,
    input  logic                        resp_done,
    output logic [CntW-1:0]             outstanding
);

    localparam int unsigned MO      = p_mem_opaque_nbits;
    localparam int unsigned MA      = p_mem_addr_nbits;
    localparam int unsigned MD      = p_mem_data_nbits;
    localparam int unsigned NS      = p_net_srcdest_nbits;
    localparam int unsigned NO      = p_net_opaque_nbits;
    localparam int unsigned AddrLsb = MD + LenW;
    localparam int unsigned OpqLsb  = AddrLsb + MA;
    localparam int unsigned TypeLsb = OpqLsb + MO;
    localparam int unsigned BankW   = (p_num_banks > 1) ? $clog2(p_num_banks) : 1;
    localparam int unsigned LineLsb = 2 + $clog2(p_cacheline_nwords);

    localparam logic [NS-1:0] SrcId  = NS'(p_net_src);
    localparam logic          Domain = (p_net_src % 2) == 1;

    typedef enum logic [1:0] {StIdle, StSend, StWaitCtrl, StWaitData} state_e;

    state_e          state_q, state_d;
    logic            live_q;
    logic [NetW-1:0] ctrl_msg_q, ctrl_msg_d;
    logic [MD-1:0]   data_msg_q, data_msg_d;

    logic [2:0]      req_type;
    logic [MO-1:0]   req_opq;
    logic [MA-1:0]   req_addr;
    logic [LenW-1:0] req_len;
    logic [MD-1:0]   req_data;
    logic [NS-1:0]   dest;
    logic [MA-1:0]   boundary;
    logic            needs_data;
    logic            credit_ok;
    logic            req_fire, ctrl_fire, data_fire;

    assign req_type = req_msg[TypeLsb +: 3];
    assign req_opq  = req_msg[OpqLsb +: MO];
    assign req_addr = req_msg[AddrLsb +: MA];
    assign req_len  = req_msg[MD +: LenW];
    assign req_data = req_msg[MD-1:0];

    // The opaque bits displaced by the source id are deliberately dropped.
    logic unused_opq_hi;
    assign unused_opq_hi = ^req_opq[MO-1:MO-NS];

    always_comb begin
        dest     = '0;
        boundary = mode ? MA'(p_data_boundary) : MA'(p_inst_boundary);
        if (p_num_banks > 1) begin
            if (p_dest_mode == 0) begin
                dest = NS'(req_addr[LineLsb +: BankW]);
            end else begin
                dest = (req_addr < boundary) ? '0 : NS'(1);
            end
        end
    end

    assign needs_data = (req_type == 3'd1) || (req_type == 3'd2);

    always_comb begin
        net_ctrl_val = (state_q == StSend) || (state_q == StWaitCtrl);
        net_data_val = (state_q == StSend) || (state_q == StWaitData);
        net_ctrl_msg = ctrl_msg_q;
        net_data_msg = data_msg_q;
        req_rdy      = live_q && (state_q == StIdle) && credit_ok;
        req_fire     = req_val && req_rdy;
        ctrl_fire    = net_ctrl_val && net_ctrl_rdy;
        data_fire    = net_data_val && net_data_rdy;
    end

    always_comb begin
        state_d    = state_q;
        ctrl_msg_d = ctrl_msg_q;
        data_msg_d = data_msg_q;
        if (req_fire) begin
            ctrl_msg_d = {dest, SrcId, {NO{1'b0}}, Domain, req_type, SrcId,
                          req_opq[MO-NS-1:0], req_addr, req_len};
            data_msg_d = req_data;
        end
        unique case (state_q)
            // A read has nothing for the data channel, so it skips straight to WAIT_CTRL.
            StIdle:     if (req_fire) state_d = needs_data ? StSend : StWaitCtrl;
            StSend: begin
                if (ctrl_fire && data_fire) state_d = StIdle;
                else if (ctrl_fire)         state_d = StWaitData;
                else if (data_fire)         state_d = StWaitCtrl;
            end
            StWaitCtrl: if (ctrl_fire) state_d = StIdle;
            StWaitData: if (data_fire) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            live_q     <= 1'b0;
            ctrl_msg_q <= '0;
            data_msg_q <= '0;
        end else begin
            state_q    <= state_d;
            live_q     <= 1'b1;
            ctrl_msg_q <= ctrl_msg_d;
            data_msg_q <= data_msg_d;
        end
    end

`ifdef PLAB5_MCORE_MEM_NET_ADAPTER_CREDIT_EN
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            retire;

    // A retirement with nothing outstanding is ignored so the count cannot wrap.
    always_comb begin
        retire = resp_done && (cnt_q != '0);
        cnt_d  = cnt_q;
        if (req_fire && !retire) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!req_fire && retire) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign credit_ok   = cnt_q < CntW'(p_max_outstanding);
    assign outstanding = cnt_q;
`else
    logic unused_resp_done;
    assign unused_resp_done = resp_done;
    assign credit_ok        = 1'b1;
    assign outstanding      = '0;
`endif

endmodule

// File: tb/tb_plab5_mcore_mem_req_net_adapter.sv
// Scoreboard bench: two adapters (region split / 4-bank interleaved) share one stimulus stream.
`timescale 1ns/1ps
module tb_plab5_mcore_mem_req_net_adapter;

    localparam int NetW = 56;
    localparam int ReqW = 77;
`ifdef PLAB5_MCORE_MEM_NET_ADAPTER_CREDIT_EN
    localparam bit CreditEn = 1'b1;
`else
    localparam bit CreditEn = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  t;
        logic [7:0]  opq;
        logic [31:0] addr;
        logic [31:0] data;
        logic        md;
        logic [2:0]  da;   // expected dest, region-split adapter
        logic [2:0]  db;   // expected dest, interleaved adapter
        logic [7:0]  eo;   // expected repacked opaque
    } vec_t;

    logic clk = 1'b0, reset = 1'b0, mode = 1'b0, req_val = 1'b0, resp_done = 1'b0;
    logic net_ctrl_rdy = 1'b1, net_data_rdy = 1'b1;
    logic [ReqW-1:0] req_msg = '0;
    logic req_rdy_a, req_rdy_b, ctrl_val_a, ctrl_val_b, data_val_a, data_val_b;
    logic [NetW-1:0] ctrl_msg_a, ctrl_msg_b;
    logic [31:0] data_msg_a, data_msg_b;
    logic [1:0] out_a, out_b;

    int checks = 0;
    int errors = 0;
    logic [NetW-1:0] ctrl_qa[$], ctrl_qb[$];
    logic [31:0]     data_qa[$], data_qb[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    plab5_mcore_mem_req_net_adapter #(
        .p_net_src(3), .p_num_banks(2), .p_dest_mode(1), .p_max_outstanding(2)
    ) u_dut_a (
        .clk(clk), .reset(reset), .mode(mode), .req_val(req_val), .req_rdy(req_rdy_a),
        .req_msg(req_msg), .net_ctrl_val(ctrl_val_a), .net_ctrl_rdy(net_ctrl_rdy),
        .net_ctrl_msg(ctrl_msg_a), .net_data_val(data_val_a), .net_data_rdy(net_data_rdy),
        .net_data_msg(data_msg_a), .resp_done(resp_done), .outstanding(out_a)
    );

    plab5_mcore_mem_req_net_adapter #(
        .p_net_src(3), .p_num_banks(4), .p_dest_mode(0), .p_max_outstanding(2)
    ) u_dut_b (
        .clk(clk), .reset(reset), .mode(mode), .req_val(req_val), .req_rdy(req_rdy_b),
        .req_msg(req_msg), .net_ctrl_val(ctrl_val_b), .net_ctrl_rdy(net_ctrl_rdy),
        .net_ctrl_msg(ctrl_msg_b), .net_data_val(data_val_b), .net_data_rdy(net_data_rdy),
        .net_data_msg(data_msg_b), .resp_done(resp_done), .outstanding(out_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_out(input int k);
        return CreditEn ? 64'(k) : 64'd0;
    endfunction

    function automatic logic [NetW-1:0] exp_ctrl(input logic [2:0] dest, input vec_t v);
        return {dest, 3'd3, 4'd0, 1'b1, v.t, v.eo, v.addr, 2'b00};
    endfunction

    task automatic send(input vec_t v, input logic rsp);
        int n = 0;
        req_val = 1'b1;
        req_msg = {v.t, v.opq, v.addr, 2'b00, v.data};
        mode    = v.md;
        @(negedge clk);
        while (!req_rdy_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_rdy_a) begin
            check("req_accept_timeout", req_rdy_a, 1);
            req_val = 1'b0;
            return;
        end
        ctrl_qa.push_back(exp_ctrl(v.da, v));
        ctrl_qb.push_back(exp_ctrl(v.db, v));
        if (v.t == 3'd1 || v.t == 3'd2) begin
            data_qa.push_back(v.data);
            data_qb.push_back(v.data);
        end
        resp_done = rsp;
        @(posedge clk);
        #1;
        req_val   = 1'b0;
        resp_done = 1'b0;
    endtask

    task automatic retire();
        @(posedge clk);
        #1 resp_done = 1'b1;
        @(posedge clk);
        #1 resp_done = 1'b0;
    endtask

    // Monitor: every completed flit must match the head of its channel's queue.
    always @(negedge clk) begin
        if (reset) begin
            if (ctrl_val_a && net_ctrl_rdy) begin
                check("ctrl_a_expected", ctrl_qa.size() != 0, 1);
                if (ctrl_qa.size() != 0) check("ctrl_a_msg", ctrl_msg_a, ctrl_qa.pop_front());
            end
            if (ctrl_val_b && net_ctrl_rdy) begin
                check("ctrl_b_expected", ctrl_qb.size() != 0, 1);
                if (ctrl_qb.size() != 0) check("ctrl_b_msg", ctrl_msg_b, ctrl_qb.pop_front());
            end
            if (data_val_a && net_data_rdy) begin
                check("data_a_expected", data_qa.size() != 0, 1);
                if (data_qa.size() != 0) check("data_a_msg", data_msg_a, data_qa.pop_front());
            end
            if (data_val_b && net_data_rdy) begin
                check("data_b_expected", data_qb.size() != 0, 1);
                if (data_qb.size() != 0) check("data_b_msg", data_msg_b, data_qb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t bp, c1, c2, c3, rw;
        vecs[0] = '{3'd0, 8'hA5, 32'h5000, 32'h0,        1'b0, 3'd1, 3'd0, 8'h65};
        vecs[1] = '{3'd0, 8'hA5, 32'h5000, 32'h0,        1'b1, 3'd0, 3'd0, 8'h65};
        vecs[2] = '{3'd1, 8'hA5, 32'h5000, 32'hDEADBEEF, 1'b1, 3'd0, 3'd0, 8'h65};
        vecs[3] = '{3'd0, 8'h11, 32'h0000, 32'h0,        1'b0, 3'd0, 3'd0, 8'h71};
        vecs[4] = '{3'd0, 8'h22, 32'h0010, 32'h0,        1'b0, 3'd0, 3'd1, 8'h62};
        vecs[5] = '{3'd0, 8'h33, 32'h0020, 32'h0,        1'b0, 3'd0, 3'd2, 8'h73};
        vecs[6] = '{3'd0, 8'h44, 32'h0030, 32'h0,        1'b0, 3'd0, 3'd3, 8'h64};
        bp = '{3'd2, 8'h0F, 32'hC000, 32'h12345678, 1'b1, 3'd1, 3'd0, 8'h6F};
        c1 = '{3'd0, 8'h01, 32'h0040, 32'h0,        1'b0, 3'd0, 3'd0, 8'h61};
        c2 = '{3'd0, 8'h1F, 32'h0050, 32'h0,        1'b0, 3'd0, 3'd1, 8'h7F};
        c3 = '{3'd0, 8'hE0, 32'h7070, 32'h0,        1'b0, 3'd1, 3'd3, 8'h60};
        rw = '{3'd1, 8'h5A, 32'h8000, 32'hCAFEF00D, 1'b1, 3'd0, 3'd0, 8'h7A};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_rdy", req_rdy_a, 0);
        check("rst_ctrl_val", ctrl_val_a, 0);
        check("rst_data_val", data_val_a, 0);
        check("rst_outstanding", out_a, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_rdy_release", req_rdy_a, 0);
        @(negedge clk);
        check("rst_rdy_after", req_rdy_a, 1);
        @(posedge clk);
        #1;

        // Directed requests, both channels always ready
        for (int i = 0; i < 7; i++) begin
            send(vecs[i], 1'b0);
            @(negedge clk);
            check("lat_ctrl_val", ctrl_val_a, 1);
            check("lat_data_val", data_val_a, vecs[i].t != 3'd0);
            check("busy_req_rdy", req_rdy_a, 0);
            check("acc_outstanding", out_a, exp_out(1));
            retire();
        end

        // Control backpressure: data completes first, control held
        net_ctrl_rdy = 1'b0;
        send(bp, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ctrl_held", ctrl_val_a, 1);
            check("bp_req_rdy", req_rdy_a, 0);
            if (k > 0) check("bp_data_done", data_val_a, 0);
        end
        @(posedge clk);
        #1 net_ctrl_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_rdy_back", req_rdy_a, 1);
        check("bp_ctrl_done", ctrl_val_a, 0);
        retire();

        // Credit limit of two
        send(c1, 1'b0);
        send(c2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("cr_stall_rdy", req_rdy_a, !CreditEn);
        check("cr_stall_out", out_a, exp_out(2));
        check("cr_stall_out_b", out_b, exp_out(2));
        retire();
        @(negedge clk);
        check("cr_ret_out", out_a, exp_out(1));
        check("cr_ret_rdy", req_rdy_a, 1);
        @(posedge clk);
        #1;
        send(c3, 1'b1);
        @(negedge clk);
        check("cr_simul_out", out_a, exp_out(1));
        retire();
        @(negedge clk);
        check("cr_zero_out", out_a, 0);
        retire();
        @(negedge clk);
        check("cr_saturate_out", out_a, 0);
        @(posedge clk);
        #1;

        // Reset while waiting on the data channel
        net_data_rdy = 1'b0;
        send(rw, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("wd_data_val", data_val_a, 1);
        check("wd_ctrl_val", ctrl_val_a, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        data_qa.delete();
        data_qb.delete();
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_data_val", data_val_a, 0);
        check("mid_rst_ctrl_val", ctrl_val_a, 0);
        check("mid_rst_out", out_a, 0);
        check("mid_rst_rdy", req_rdy_a, 0);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        net_data_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_rdy", req_rdy_a, 1);
        check("post_rst_data_val", data_val_a, 0);
        repeat (5) @(negedge clk);

        check("ctrl_qa_drained", ctrl_qa.size(), 0);
        check("ctrl_qb_drained", ctrl_qb.size(), 0);
        check("data_qa_drained", data_qa.size(), 0);
        check("data_qb_drained", data_qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
